// File: rtl/zube_bus_sequencer.sv
// zube_bus_sequencer
//
// Z80 I/O cycle controller for the zube mailbox. The slow, asynchronous Z80
// strobes are synchronised into the clk domain, and their falling edges are
// decoded against a two-port I/O window (base_address, base_address+1).
// Writes produce single-cycle register write enables. Reads produce a capture
// pulse and then sequence the external transceiver: it drives while the read
// strobe is held, then the bus stays undriven for a turnaround period. The
// block also owns the mailbox full/overrun flags and the SoC interrupt.
//
// Parameters
//   SYNC_STAGES  flops in each strobe synchroniser (2..3)
//   TURN_CYCLES  undriven cycles after a read before a new cycle is accepted (>=1)
//
// Ports
//   clk                 high-speed clock
//   reset               asynchronous, active-high reset
//   z80_write_strobe_b  Z80 write strobe, active low, asynchronous
//   z80_read_strobe_b   Z80 read strobe, active low, asynchronous
//   z80_address_bus     Z80 A[7:0]
//   base_address        I/O window base
//   soc_data_wr         pulse: SoC wrote the Data In register
//   soc_data_rd         pulse: SoC read the Data Out register
//   soc_clr_overrun     pulse: clear the overrun flag
//   data_out_we         pulse: Z80 wrote offset 0 (Data Out)
//   status_out_we       pulse: Z80 wrote offset 1 (Status Out)
//   rd_latch            pulse: capture the read byte
//   rd_sel              read source, 0 = Data In, 1 = status_flags
//   z80_bus_dir         1 = drive the Z80 data bus through the transceiver
//   status_flags        {5'b0, overrun, data_out_full, data_in_full}
//   soc_irq             level interrupt = data_out_full | overrun

module zube_bus_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z80_write_strobe_b,
  input  logic       z80_read_strobe_b,
  input  logic [7:0] z80_address_bus,
  input  logic [7:0] base_address,
  input  logic       soc_data_wr,
  input  logic       soc_data_rd,
  input  logic       soc_clr_overrun,
  output logic       data_out_we,
  output logic       status_out_we,
  output logic       rd_latch,
  output logic       rd_sel,
  output logic       z80_bus_dir,
  output logic [7:0] status_flags,
  output logic       soc_irq
);

  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    TURN
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] wr_sync, rd_sync, sync_fill;
  logic wr_last, rd_last;
  logic wr_prev, rd_prev;
  logic wr_armed, rd_armed;
  logic wr_fall, rd_fall;
  logic wr_fall_q, rd_fall_q;
  logic [7:0] addr_q, base_q, base_plus1;
  logic match0, match1;

  logic [CW-1:0] turn_cnt, turn_cnt_next;
  logic data_out_we_next, status_out_we_next, rd_latch_next, rd_sel_next, bus_dir_next;

  logic data_out_full, data_in_full, overrun;

  assign wr_last = wr_sync[SYNC_STAGES-1];
  assign rd_last = rd_sync[SYNC_STAGES-1];

  // A strobe only counts as falling once it has been seen high with a real
  // sample; the preset-to-1 synchroniser contents after reset do not count,
  // so a strobe held low across reset release never produces a pulse.
  assign wr_fall = wr_armed & wr_prev & ~wr_last;
  assign rd_fall = rd_armed & rd_prev & ~rd_last;

  // Strobe synchronisers, edge history and arming. sync_fill marks when the
  // last synchroniser stage holds a genuine sample rather than the preset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sync   <= '1;
      rd_sync   <= '1;
      sync_fill <= '0;
      wr_prev   <= 1'b1;
      rd_prev   <= 1'b1;
      wr_armed  <= 1'b0;
      rd_armed  <= 1'b0;
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], z80_write_strobe_b};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], z80_read_strobe_b};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      wr_prev   <= wr_last;
      rd_prev   <= rd_last;
      wr_armed  <= wr_armed | (sync_fill[SYNC_STAGES-1] & wr_last);
      rd_armed  <= rd_armed | (sync_fill[SYNC_STAGES-1] & rd_last);
    end
  end

  // Edge events are registered together with the address and window base,
  // so the decode below sees a stable snapshot taken when the edge was found.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_fall_q <= 1'b0;
      rd_fall_q <= 1'b0;
      addr_q    <= '0;
      base_q    <= '0;
    end else begin
      wr_fall_q <= wr_fall;
      rd_fall_q <= rd_fall;
      if (wr_fall || rd_fall) begin
        addr_q <= z80_address_bus;
        base_q <= base_address;
      end
    end
  end

  // Offset 1 wraps within 8 bits, so base 8'hFF decodes offset 1 at 8'h00.
  assign base_plus1 = base_q + 8'd1;
  assign match0     = (addr_q == base_q);
  assign match1     = (addr_q == base_plus1);

  // State, turnaround counter and registered cycle outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      turn_cnt      <= '0;
      data_out_we   <= 1'b0;
      status_out_we <= 1'b0;
      rd_latch      <= 1'b0;
      rd_sel        <= 1'b0;
      z80_bus_dir   <= 1'b0;
    end else begin
      state         <= state_next;
      turn_cnt      <= turn_cnt_next;
      data_out_we   <= data_out_we_next;
      status_out_we <= status_out_we_next;
      rd_latch      <= rd_latch_next;
      rd_sel        <= rd_sel_next;
      z80_bus_dir   <= bus_dir_next;
    end
  end

  // Next-state and output decode. Both strobes low is an invalid cycle: it
  // is parked in WRITE without any pulse until both strobes are released.
  // The transceiver drives only while READ is held; leaving READ for TURN
  // drops it on the same edge.
  always_comb begin
    state_next         = state;
    turn_cnt_next      = turn_cnt;
    data_out_we_next   = 1'b0;
    status_out_we_next = 1'b0;
    rd_latch_next      = 1'b0;
    rd_sel_next        = rd_sel;
    bus_dir_next       = 1'b0;
    case (state)
      IDLE: begin
        if ((wr_fall_q || rd_fall_q) && !wr_last && !rd_last) begin
          state_next = WRITE;
        end else if (wr_fall_q && (match0 || match1)) begin
          state_next         = WRITE;
          data_out_we_next   = match0;
          status_out_we_next = match1;
        end else if (rd_fall_q && (match0 || match1)) begin
          state_next    = READ;
          rd_latch_next = 1'b1;
          rd_sel_next   = match1;
        end
      end
      WRITE: begin
        if (wr_last && rd_last) begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (rd_last) begin
          state_next    = TURN;
          turn_cnt_next = '0;
        end else begin
          bus_dir_next = 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_next = IDLE;
        end else begin
          turn_cnt_next = turn_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Mailbox flags. In every case a set request wins over a simultaneous
  // clear. Only Data Out writes touch data_out_full and overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_full <= 1'b0;
      data_in_full  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (data_out_we) begin
        data_out_full <= 1'b1;
      end else if (soc_data_rd) begin
        data_out_full <= 1'b0;
      end
      if (soc_data_wr) begin
        data_in_full <= 1'b1;
      end else if (rd_latch && !rd_sel) begin
        data_in_full <= 1'b0;
      end
      if (data_out_we && data_out_full) begin
        overrun <= 1'b1;
      end else if (soc_clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign status_flags = {5'b0, overrun, data_out_full, data_in_full};
  assign soc_irq      = data_out_full | overrun;

endmodule

// File: tb/tb_zube_bus_sequencer.sv
// tb_zube_bus_sequencer
//
// Directed bench for zube_bus_sequencer with SYNC_STAGES=2, TURN_CYCLES=4.
// Cycle indices count the clock edges after a strobe change: a strobe driven
// low before edge 0 should produce its pulse in the cycle after edge 3.

module tb_zube_bus_sequencer;

  logic       clk;
  logic       reset;
  logic       z80_write_strobe_b;
  logic       z80_read_strobe_b;
  logic [7:0] z80_address_bus;
  logic [7:0] base_address;
  logic       soc_data_wr;
  logic       soc_data_rd;
  logic       soc_clr_overrun;
  logic       data_out_we;
  logic       status_out_we;
  logic       rd_latch;
  logic       rd_sel;
  logic       z80_bus_dir;
  logic [7:0] status_flags;
  logic       soc_irq;

  int checkCount;
  int passCount;

  int idx;
  int nDow, nSow, nRdl, nDir;
  int firstDow, firstSow, firstRdl, lastRdl, firstDir, lastDir;
  logic rdSelAtLatch;

  zube_bus_sequencer #(
    .SYNC_STAGES(2),
    .TURN_CYCLES(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .z80_write_strobe_b(z80_write_strobe_b),
    .z80_read_strobe_b (z80_read_strobe_b),
    .z80_address_bus   (z80_address_bus),
    .base_address      (base_address),
    .soc_data_wr       (soc_data_wr),
    .soc_data_rd       (soc_data_rd),
    .soc_clr_overrun   (soc_clr_overrun),
    .data_out_we       (data_out_we),
    .status_out_we     (status_out_we),
    .rd_latch          (rd_latch),
    .rd_sel            (rd_sel),
    .z80_bus_dir       (z80_bus_dir),
    .status_flags      (status_flags),
    .soc_irq           (soc_irq)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearLog();
    idx      = 0;
    nDow     = 0;
    nSow     = 0;
    nRdl     = 0;
    nDir     = 0;
    firstDow = -1;
    firstSow = -1;
    firstRdl = -1;
    lastRdl  = -1;
    firstDir = -1;
    lastDir  = -1;
    rdSelAtLatch = 1'b0;
  endtask

  // Advance one clock and log the outputs half a cycle after the edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (data_out_we) begin
      nDow++;
      if (firstDow < 0) firstDow = idx;
    end
    if (status_out_we) begin
      nSow++;
      if (firstSow < 0) firstSow = idx;
    end
    if (rd_latch) begin
      nRdl++;
      if (firstRdl < 0) firstRdl = idx;
      lastRdl = idx;
      rdSelAtLatch = rd_sel;
    end
    if (z80_bus_dir) begin
      nDir++;
      if (firstDir < 0) firstDir = idx;
      lastDir = idx;
    end
    idx++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle SoC side pulses.
  task automatic socPulse(input bit wr, input bit rd, input bit clr);
    soc_data_wr     = wr;
    soc_data_rd     = rd;
    soc_clr_overrun = clr;
    tick();
    soc_data_wr     = 1'b0;
    soc_data_rd     = 1'b0;
    soc_clr_overrun = 1'b0;
  endtask

  // Z80 cycle: hold the chosen strobe(s) low for 'hold' edges, then release
  // and let 'tail' more edges run, logging every output pulse.
  task automatic applyStimulus(input bit doWr, input bit doRd, input logic [7:0] addr,
                               input int hold, input int tail);
    clearLog();
    z80_address_bus = addr;
    if (doWr) z80_write_strobe_b = 1'b0;
    if (doRd) z80_read_strobe_b  = 1'b0;
    ticks(hold);
    z80_write_strobe_b = 1'b1;
    z80_read_strobe_b  = 1'b1;
    ticks(tail);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    clearLog();
    reset              = 1'b1;
    z80_write_strobe_b = 1'b1;
    z80_read_strobe_b  = 1'b1;
    z80_address_bus    = 8'h00;
    base_address       = 8'h80;
    soc_data_wr        = 1'b0;
    soc_data_rd        = 1'b0;
    soc_clr_overrun    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", status_flags, 8'h00);
    checkOutput("reset_irq", soc_irq, 0);
    checkOutput("reset_dir", z80_bus_dir, 0);
    checkOutput("reset_pulses", {data_out_we, status_out_we, rd_latch, rd_sel}, 4'b0000);
    reset = 1'b0;
    ticks(6);

    // 1: Data Out write, latency and interrupt
    applyStimulus(1'b1, 1'b0, 8'h80, 10, 6);
    checkOutput("t1_dow_count", nDow, 1);
    checkOutput("t1_dow_cycle", firstDow, 3);
    checkOutput("t1_sow_count", nSow, 0);
    checkOutput("t1_dir_count", nDir, 0);
    checkOutput("t1_flags", status_flags, 8'h02);
    checkOutput("t1_irq", soc_irq, 1);
    socPulse(1'b0, 1'b1, 1'b0);
    checkOutput("t1_flags_after_rd", status_flags, 8'h00);
    checkOutput("t1_irq_after_rd", soc_irq, 0);

    // 2: status read, bus direction, turnaround boundary (accepted at its first legal cycle)
    socPulse(1'b1, 1'b0, 1'b0);
    checkOutput("t2_din_full", status_flags, 8'h01);
    clearLog();
    z80_address_bus   = 8'h81;
    z80_read_strobe_b = 1'b0;
    ticks(10);
    z80_read_strobe_b = 1'b1;
    ticks(4);
    checkOutput("t2_rdl_count", nRdl, 1);
    checkOutput("t2_rdl_cycle", firstRdl, 3);
    checkOutput("t2_rd_sel", rdSelAtLatch, 1);
    checkOutput("t2_flags_kept", status_flags, 8'h01);
    checkOutput("t2_dir_first", firstDir, 4);
    checkOutput("t2_dir_last", lastDir, 11);
    checkOutput("t2_dir_count", nDir, 8);
    z80_address_bus   = 8'h80;
    z80_read_strobe_b = 1'b0;
    ticks(6);
    checkOutput("t2_second_rdl_cycle", lastRdl, 17);
    checkOutput("t2_second_rd_sel", rdSelAtLatch, 0);
    checkOutput("t2_din_cleared", status_flags, 8'h00);
    z80_read_strobe_b = 1'b1;
    ticks(10);

    // 3: overrun
    applyStimulus(1'b1, 1'b0, 8'h80, 6, 6);
    checkOutput("t3_first_write", status_flags, 8'h02);
    applyStimulus(1'b1, 1'b0, 8'h80, 6, 6);
    checkOutput("t3_overrun", status_flags, 8'h06);
    socPulse(1'b0, 1'b0, 1'b1);
    checkOutput("t3_clr_overrun", status_flags, 8'h02);
    checkOutput("t3_irq_full", soc_irq, 1);
    socPulse(1'b0, 1'b1, 1'b0);
    checkOutput("t3_cleanup", status_flags, 8'h00);

    // 4: window wrap at base 8'hFF and foreign addresses
    base_address = 8'hFF;
    applyStimulus(1'b1, 1'b0, 8'h00, 6, 6);
    checkOutput("t4_sow_count", nSow, 1);
    checkOutput("t4_sow_cycle", firstSow, 3);
    checkOutput("t4_dow_none", nDow, 0);
    checkOutput("t4_flags_untouched", status_flags, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h7F, 6, 6);
    checkOutput("t4_foreign_write", nDow + nSow, 0);
    applyStimulus(1'b0, 1'b1, 8'h7F, 8, 8);
    checkOutput("t4_foreign_read", nRdl, 0);
    checkOutput("t4_foreign_dir", nDir, 0);
    base_address = 8'h80;

    // 5a: read fall landing in the last TURN cycle is dropped
    clearLog();
    z80_address_bus   = 8'h80;
    z80_read_strobe_b = 1'b0;
    ticks(10);
    z80_read_strobe_b = 1'b1;
    ticks(3);
    z80_read_strobe_b = 1'b0;
    ticks(10);
    checkOutput("t5_turn_ignored", nRdl, 1);
    checkOutput("t5_turn_dir", nDir, 8);
    z80_read_strobe_b = 1'b1;
    ticks(8);

    // 5b: both strobes low together, then recovery with a Status Out write
    applyStimulus(1'b1, 1'b1, 8'h80, 6, 8);
    checkOutput("t5_both_low_pulses", nDow + nSow + nRdl, 0);
    checkOutput("t5_both_low_dir", nDir, 0);
    applyStimulus(1'b1, 1'b0, 8'h81, 6, 6);
    checkOutput("t5_recover_sow", nSow, 1);
    checkOutput("t5_sow_no_flags", status_flags, 8'h00);

    // 5c: asynchronous reset while driving, strobe held across release
    clearLog();
    z80_address_bus   = 8'h80;
    z80_read_strobe_b = 1'b0;
    ticks(6);
    checkOutput("t5_dir_before_reset", z80_bus_dir, 1);
    reset = 1'b1;
    #1;
    checkOutput("t5_dir_async_drop", z80_bus_dir, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clearLog();
    ticks(12);
    checkOutput("t5_held_no_rdl", nRdl, 0);
    checkOutput("t5_held_no_dir", nDir, 0);
    z80_read_strobe_b = 1'b1;
    ticks(6);
    applyStimulus(1'b0, 1'b1, 8'h80, 6, 8);
    checkOutput("t5_post_reset_rdl", firstRdl, 3);

    // 6: simultaneous set and clear of the full flags
    clearLog();
    z80_address_bus    = 8'h80;
    z80_write_strobe_b = 1'b0;
    ticks(4);
    checkOutput("t6_dow_now", data_out_we, 1);
    soc_data_rd = 1'b1;
    tick();
    soc_data_rd = 1'b0;
    checkOutput("t6_dout_full_wins", status_flags, 8'h02);
    z80_write_strobe_b = 1'b1;
    ticks(6);
    clearLog();
    z80_read_strobe_b = 1'b0;
    ticks(4);
    checkOutput("t6_rdl_now", rd_latch, 1);
    soc_data_wr = 1'b1;
    tick();
    soc_data_wr = 1'b0;
    checkOutput("t6_din_full_wins", status_flags, 8'h03);
    z80_read_strobe_b = 1'b1;
    ticks(10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
